// File: rtl/perf_counters.sv
// perf_counters: N-channel performance counters sequenced by a shared IDLE/RUN/HALT FSM.
// Each channel counts in OFF / CYCLES / LEVEL / EDGE mode and has a sticky overflow flag.
// Optional build macro: PERF_SNAPSHOT_EN adds per-channel shadow registers that capture
// the counters on RUN->HALT; rd_data then reads the shadows instead of the live counters.
//
// state | meaning
// IDLE  | cleared/armed, waiting for start to drop
// RUN   | counting enabled while done is low
// HALT  | counting frozen until the next start
//
// The port is called events because event is a reserved word.
module perf_counters #(
    parameter int W        = 16,
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic                                 CLK,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 done,
    input  logic [N-1:0]                         events,
    input  logic                                 cfg_we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] cfg_sel,
    input  logic [1:0]                           cfg_mode,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] rd_sel,
    output logic [W-1:0]                         rd_data,
    output logic [N-1:0]                         ovf,
    output logic                                 running
);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_CYCLES = 2'd1;
    localparam logic [1:0] MODE_LEVEL  = 2'd2;
    localparam logic [1:0] MODE_EDGE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] cnt  [N];
    logic [1:0]   mode [N];
    logic [N-1:0] prev_ev;
    logic [N-1:0] inc;
    logic         count_en;
    logic         halt_entry;
    logic [31:0]  cfg_idx;
    logic [31:0]  rd_idx;

    // Widened selects so out-of-range channel numbers compare cleanly against N.
    assign cfg_idx = 32'(cfg_sel);
    assign rd_idx  = 32'(rd_sel);

    // start dominates done, which dominates counting.
    assign count_en   = (state == RUN) && !done && !start;
    assign halt_entry = (state == RUN) && done && !start;

    // Global sequencer; running is a registered copy of "in RUN".
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else if (start) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    if (done) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end
                end
                HALT: begin
                    state   <= HALT;
                    running <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel increment request from the channel mode and event history.
    always_comb begin
        inc = '0;
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                MODE_OFF:    inc[i] = 1'b0;
                MODE_CYCLES: inc[i] = 1'b1;
                MODE_LEVEL:  inc[i] = events[i];
                MODE_EDGE:   inc[i] = events[i] & ~prev_ev[i];
            endcase
        end
    end

    // Mode registers; writes are accepted in every state, out-of-range selects are dropped.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) mode[i] <= MODE_CYCLES;
        end else if (cfg_we) begin
            for (int i = 0; i < N; i++) begin
                if (cfg_idx == 32'(i)) mode[i] <= cfg_mode;
            end
        end
    end

    // Counters, sticky overflow flags and edge-detect history.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            ovf     <= '0;
            prev_ev <= '0;
        end else if (start) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            ovf     <= '0;
            prev_ev <= '0;
        end else begin
            prev_ev <= events;
            if (count_en) begin
                for (int i = 0; i < N; i++) begin
                    if (inc[i]) begin
                        if (&cnt[i]) begin
                            ovf[i] <= 1'b1;
                            cnt[i] <= (SATURATE != 0) ? cnt[i] : '0;
                        end else begin
                            cnt[i] <= cnt[i] + W'(1);
                        end
                    end
                end
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [W-1:0] shadow [N];

    // Shadows freeze the counter values at the moment RUN hands over to HALT.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) shadow[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < N; i++) shadow[i] <= '0;
        end else if (halt_entry) begin
            for (int i = 0; i < N; i++) shadow[i] <= cnt[i];
        end
    end

    // Zero-latency readout of the selected shadow; unknown channels read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx == 32'(i)) rd_data = shadow[i];
        end
    end
`else
    // halt_entry only matters when shadows exist.
    logic unused_halt;
    assign unused_halt = halt_entry;

    // Zero-latency readout of the selected live counter; unknown channels read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx == 32'(i)) rd_data = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_perf_counters.sv
// Bench for perf_counters: three instances share one stimulus stream
// (W=16/N=4 wrapping, W=4/N=3 wrapping, W=4/N=3 saturating) and are compared
// against an unbounded-count reference model derived from the channel rules.
module tb_perf_counters;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_HALT = 2;

    logic        CLK      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        done     = 1'b0;
    logic [3:0]  events   = 4'd0;
    logic        cfg_we   = 1'b0;
    logic [1:0]  cfg_sel  = 2'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [1:0]  rd_sel   = 2'd0;

    logic [15:0] rd_m;
    logic [3:0]  rd_w;
    logic [3:0]  rd_s;
    logic [3:0]  ovf_m;
    logic [2:0]  ovf_w;
    logic [2:0]  ovf_s;
    logic        running_m;
    logic        running_w;
    logic        running_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 CLK = ~CLK;

    perf_counters #(.W(16), .N(4), .SATURATE(0)) dut_m (
        .CLK(CLK), .reset_n(reset_n), .start(start), .done(done), .events(events),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .rd_sel(rd_sel),
        .rd_data(rd_m), .ovf(ovf_m), .running(running_m)
    );

    perf_counters #(.W(4), .N(3), .SATURATE(0)) dut_w (
        .CLK(CLK), .reset_n(reset_n), .start(start), .done(done), .events(events[2:0]),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .rd_sel(rd_sel),
        .rd_data(rd_w), .ovf(ovf_w), .running(running_w)
    );

    perf_counters #(.W(4), .N(3), .SATURATE(1)) dut_s (
        .CLK(CLK), .reset_n(reset_n), .start(start), .done(done), .events(events[2:0]),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .rd_sel(rd_sel),
        .rd_data(rd_s), .ovf(ovf_s), .running(running_s)
    );

    // Reference model: true event totals without width limits; wrap/saturate applied on read.
    longint tot [3][4];
    longint shd [3][4];
    int     md  [3][4];
    bit     prv [3][4];
    int     phase;

    function automatic int dn(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int dwid(int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic longint shown(int d, longint t);
        longint lim;
        lim = longint'(1) << dwid(d);
        if (d == 2) return (t >= lim - 1) ? lim - 1 : t;
        return t % lim;
    endfunction

    function automatic logic [15:0] exp_rd(int d, int s);
        if (s >= dn(d)) return 16'd0;
`ifdef PERF_SNAPSHOT_EN
        return 16'(shown(d, shd[d][s]));
`else
        return 16'(shown(d, tot[d][s]));
`endif
    endfunction

    function automatic logic [3:0] exp_ovf(int d);
        logic [3:0] v;
        v = 4'd0;
        for (int c = 0; c < dn(d); c++) v[c] = (tot[d][c] >= (longint'(1) << dwid(d)));
        return v;
    endfunction

    function automatic logic [15:0] got_rd(int d);
        case (d)
            0:       return rd_m;
            1:       return {12'd0, rd_w};
            default: return {12'd0, rd_s};
        endcase
    endfunction

    function automatic logic [3:0] got_ovf(int d);
        case (d)
            0:       return ovf_m;
            1:       return {1'b0, ovf_w};
            default: return {1'b0, ovf_s};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                tot[d][c] = 0;
                shd[d][c] = 0;
                md[d][c]  = 1;
                prv[d][c] = 1'b0;
            end
        end
        phase = P_IDLE;
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < dn(d); c++) begin
                if (start) begin
                    tot[d][c] = 0;
                    shd[d][c] = 0;
                    prv[d][c] = 1'b0;
                end else begin
                    if (phase == P_RUN && !done) begin
                        if (md[d][c] == 1) tot[d][c]++;
                        if (md[d][c] == 2 && events[c]) tot[d][c]++;
                        if (md[d][c] == 3 && events[c] && !prv[d][c]) tot[d][c]++;
                    end
                    if (phase == P_RUN && done) shd[d][c] = tot[d][c];
                    prv[d][c] = events[c];
                end
            end
            if (cfg_we && int'(cfg_sel) < dn(d)) md[d][cfg_sel] = int'(cfg_mode);
        end
        if (start) phase = P_IDLE;
        else if (phase == P_IDLE) phase = P_RUN;
        else if (phase == P_RUN && done) phase = P_HALT;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (got_rd(d) !== 16'd0)
                    $display("FAIL reset_rd dut%0d ch%0d: got %0d want 0", d, s, got_rd(d));
                else n_pass++;
            end
        end
        n_checks++;
        if ({ovf_m, ovf_w, ovf_s, running_m, running_w, running_s} !== 13'd0)
            $display("FAIL reset_flags: got ovf %b/%b/%b run %b%b%b want zeros",
                     ovf_m, ovf_w, ovf_s, running_m, running_w, running_s);
        else n_pass++;
        start   = 1'b1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_cycles();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        repeat (11) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_checks++;
        if (rd_m !== 16'd10) $display("FAIL cycles_count: got %0d want 10", rd_m);
        else n_pass++;
        n_checks++;
        if (running_m !== 1'b0) $display("FAIL cycles_running: got %b want 0", running_m);
        else n_pass++;
        repeat (20) tick();
        n_checks++;
        if (rd_m !== 16'd10) $display("FAIL cycles_hold: got %0d want 10", rd_m);
        else n_pass++;
    endtask

    task automatic test_edge_level();
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_sel  = 2'd1;
        cfg_mode = 2'd2;
        tick();
        cfg_sel  = 2'd2;
        cfg_mode = 2'd3;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        events = 4'b0000;
        tick();
        events = 4'b0110;
        repeat (3) tick();
        events = 4'b0000;
        repeat (2) tick();
        events = 4'b0110;
        repeat (4) tick();
        events = 4'b0000;
        done   = 1'b1;
        tick();
        done = 1'b0;
        rd_sel = 2'd1;
        #1;
        n_checks++;
        if (rd_m !== 16'd7 || rd_w !== 4'd7) $display("FAIL level_count: got %0d/%0d want 7", rd_m, rd_w);
        else n_pass++;
        rd_sel = 2'd2;
        #1;
        n_checks++;
        if (rd_m !== 16'd2 || rd_s !== 4'd2) $display("FAIL edge_count: got %0d/%0d want 2", rd_m, rd_s);
        else n_pass++;
    endtask

    task automatic test_wrap_saturate();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (18) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_checks++;
        if (rd_w !== 4'd2) $display("FAIL wrap_value: got %0d want 2", rd_w);
        else n_pass++;
        n_checks++;
        if (rd_s !== 4'd15) $display("FAIL sat_value: got %0d want 15", rd_s);
        else n_pass++;
        n_checks++;
        if (ovf_w[0] !== 1'b1 || ovf_s[0] !== 1'b1) $display("FAIL wrap_ovf: got %b/%b want 1/1", ovf_w[0], ovf_s[0]);
        else n_pass++;
        n_checks++;
        if (rd_m !== 16'd18 || ovf_m[0] !== 1'b0) $display("FAIL wide_no_ovf: got %0d ovf %b want 18 ovf 0", rd_m, ovf_m[0]);
        else n_pass++;
    endtask

    task automatic test_mode_change();
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_sel  = 2'd3;
        cfg_mode = 2'd1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        tick();
        repeat (4) begin
            events = 4'($urandom);
            tick();
        end
        cfg_we   = 1'b1;
        cfg_sel  = 2'd3;
        cfg_mode = 2'd0;
        tick();
        cfg_we = 1'b0;
        repeat (5) begin
            events = 4'($urandom);
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        rd_sel = 2'd3;
        #1;
        n_checks++;
        if (rd_m !== 16'd5) $display("FAIL mode_off_count: got %0d want 5", rd_m);
        else n_pass++;
        n_checks++;
        if (rd_w !== 4'd0) $display("FAIL rd_sel_out_of_range: got %0d want 0", rd_w);
        else n_pass++;
        rd_sel = 2'd0;
        #1;
        n_checks++;
        if (rd_w !== 4'd10 || rd_s !== 4'd10) $display("FAIL ignored_cfg_sel: got %0d/%0d want 10", rd_w, rd_s);
        else n_pass++;
        for (int s = 1; s < 3; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (got_rd(d) !== exp_rd(d, s))
                    $display("FAIL mode_model_rd dut%0d ch%0d: got %0d want %0d", d, s, got_rd(d), exp_rd(d, s));
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_sel  = 2'd0;
        cfg_mode = 2'd1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        events = 4'd0;
        tick();
        repeat (6) tick();
        #3;
        reset_n = 1'b0;
        start   = 1'b1;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (got_rd(d) !== 16'd0)
                    $display("FAIL async_rd dut%0d ch%0d: got %0d want 0", d, s, got_rd(d));
                else n_pass++;
            end
        end
        n_checks++;
        if ({ovf_m, ovf_w, ovf_s, running_m, running_w, running_s} !== 13'd0)
            $display("FAIL async_flags: got ovf %b/%b/%b run %b%b%b want zeros",
                     ovf_m, ovf_w, ovf_s, running_m, running_w, running_s);
        else n_pass++;
        #2;
        reset_n = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        rd_sel = 2'd3;
        #1;
        n_checks++;
        if (rd_m !== 16'd3) $display("FAIL async_modes_cycles: got %0d want 3", rd_m);
        else n_pass++;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (got_rd(d) !== exp_rd(d, s))
                    $display("FAIL async_after_rd dut%0d ch%0d: got %0d want %0d", d, s, got_rd(d), exp_rd(d, s));
                else n_pass++;
            end
        end
    endtask

`ifdef PERF_SNAPSHOT_EN
    task automatic test_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (8) tick();
        done = 1'b1;
        tick();
        done  = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_checks++;
        if (rd_m !== 16'd0) $display("FAIL snap_cleared: got %0d want 0", rd_m);
        else n_pass++;
        tick();
        repeat (4) tick();
        n_checks++;
        if (rd_m !== 16'd0) $display("FAIL snap_hold_in_run: got %0d want 0", rd_m);
        else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (rd_m !== 16'd4) $display("FAIL snap_capture: got %0d want 4", rd_m);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        start = 1'b1;
        tick();
        for (int it = 0; it < 300; it++) begin
            start    = ($urandom_range(0, 49) == 0);
            done     = ($urandom_range(0, 29) == 0);
            events   = 4'($urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_sel  = 2'($urandom);
            cfg_mode = 2'($urandom);
            tick();
            for (int s = 0; s < 4; s++) begin
                rd_sel = 2'(s);
                #1;
                for (int d = 0; d < 3; d++) begin
                    n_checks++;
                    if (got_rd(d) !== exp_rd(d, s))
                        $display("FAIL random_rd it%0d dut%0d ch%0d: got %0d want %0d",
                                 it, d, s, got_rd(d), exp_rd(d, s));
                    else n_pass++;
                end
            end
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (got_ovf(d) !== exp_ovf(d))
                    $display("FAIL random_ovf it%0d dut%0d: got %b want %b", it, d, got_ovf(d), exp_ovf(d));
                else n_pass++;
            end
            n_checks++;
            if ({running_m, running_w, running_s} !== {3{phase == P_RUN}})
                $display("FAIL random_running it%0d: got %b%b%b want %b",
                         it, running_m, running_w, running_s, phase == P_RUN);
            else n_pass++;
        end
        start  = 1'b0;
        done   = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cycles();
        test_edge_level();
        test_wrap_saturate();
        test_mode_change();
        test_async_reset();
`ifdef PERF_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
